// File: rtl/eth_tx_framer_pkg.sv
// Shared Ethernet framing constants, TX state encoding and the byte-wise CRC-32 step
// used by both the TX framer and the RX frame checker.
package eth_tx_framer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
    localparam logic [7:0]  SFD_BYTE             = 8'hD5;
    localparam int unsigned PREAMBLE_LEN         = 7;
    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB_20E3;
    localparam int unsigned MIN_BODY_BYTES       = 60;
    localparam int unsigned IFG_BYTES            = 12;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    // One reflected byte update; no final inversion.
    function automatic logic [31:0] crc32_next(input logic [7:0] data, input logic [31:0] crc);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// Transmit framer: wraps a valid/ready body stream with preamble, SFD, zero padding,
// FCS and inter-frame gap onto a registered byte-wide PHY interface.
module eth_tx_framer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MIN_BODY_BYTES = eth_tx_framer_pkg::MIN_BODY_BYTES,
    parameter int unsigned IFG_BYTES      = eth_tx_framer_pkg::IFG_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_en,
    output logic                  tx_done,
    output logic                  underrun
);
    import eth_tx_framer_pkg::*;

    // state_q names the byte produced at the next edge, so outputs land registered.
    tx_state_e   state_q;
    logic [7:0]  step_q;
    logic [10:0] body_cnt_q;
    logic [31:0] crc_q;
    logic        bad_q;

    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;
    logic [11:0] body_inc;
    logic [10:0] body_sat;

    assign s_ready = (state_q == StData);

    always_comb begin
        fcs_word = bad_q ? crc_q : ~crc_q;
        unique case (step_q[1:0])
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
        body_inc = {1'b0, body_cnt_q} + 12'd1;
        body_sat = (&body_cnt_q) ? body_cnt_q : body_inc[10:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            body_cnt_q <= '0;
            crc_q      <= '1;
            bad_q      <= 1'b0;
            tx_data    <= '0;
            tx_en      <= 1'b0;
            tx_done    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            underrun <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_en   <= 1'b0;
                    tx_data <= '0;
                    if (s_valid) begin
                        state_q    <= StPre;
                        step_q     <= 8'd1;
                        crc_q      <= '1;
                        body_cnt_q <= '0;
                        bad_q      <= 1'b0;
                        tx_en      <= 1'b1;
                        tx_data    <= PREAMBLE_BYTE;
                    end
                end
                StPre: begin
                    tx_en   <= 1'b1;
                    tx_data <= PREAMBLE_BYTE;
                    step_q  <= step_q + 8'd1;
                    if (step_q == 8'(PREAMBLE_LEN - 1)) begin
                        state_q <= StSfd;
                    end
                end
                StSfd: begin
                    tx_data <= SFD_BYTE;
                    state_q <= StData;
                end
                StData: begin
                    if (s_valid) begin
                        tx_data    <= s_data;
                        crc_q      <= crc32_next(s_data, crc_q);
                        body_cnt_q <= body_sat;
                        if (s_last) begin
                            step_q  <= '0;
                            state_q <= (body_inc < 12'(MIN_BODY_BYTES)) ? StPad : StFcs;
                        end
                    end else begin
                        // Source gap: close the frame with an inverted (guaranteed bad) FCS.
                        bad_q    <= 1'b1;
                        underrun <= 1'b1;
                        tx_data  <= crc_q[7:0];
                        step_q   <= 8'd1;
                        state_q  <= StFcs;
                    end
                end
                StPad: begin
                    tx_data    <= '0;
                    crc_q      <= crc32_next(8'h00, crc_q);
                    body_cnt_q <= body_sat;
                    if (body_inc >= 12'(MIN_BODY_BYTES)) begin
                        step_q  <= '0;
                        state_q <= StFcs;
                    end
                end
                StFcs: begin
                    tx_data <= fcs_byte;
                    step_q  <= step_q + 8'd1;
                    if (step_q == 8'd3) begin
                        tx_done <= 1'b1;
                        step_q  <= '0;
                        state_q <= StIfg;
                    end
                end
                StIfg: begin
                    tx_en   <= 1'b0;
                    tx_data <= '0;
                    step_q  <= step_q + 8'd1;
                    // Final IFG step: a waiting source starts the preamble with no extra idle.
                    if (step_q == 8'(IFG_BYTES)) begin
                        if (s_valid) begin
                            state_q    <= StPre;
                            step_q     <= 8'd1;
                            crc_q      <= '1;
                            body_cnt_q <= '0;
                            bad_q      <= 1'b0;
                            tx_en      <= 1'b1;
                            tx_data    <= PREAMBLE_BYTE;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
